// File: rtl/counter_sampler.sv
// Avalon-MM master that reads a 64-bit cycle counter as two 32-bit words and
// presents a coherent snapshot. Define COUNTER_SAMPLER_COHERENT_EN for hi-lo-hi reads with retry.
module counter_sampler #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE, REQ_HI0, WT_HI0, REQ_LO, WT_LO, REQ_HI1, WT_HI1, FIN
  } state_t;

  localparam logic [31:0] HI_ADDR = BASE_ADDR + 32'd4;

  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_max_retry_range
    $error("counter_sampler: MAX_RETRY must be within 1..15");
  end

  state_t      state_q, state_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] result_q, result_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef COUNTER_SAMPLER_COHERENT_EN
  localparam state_t      FIRST_REQ = REQ_HI0;
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
  logic [31:0] hi0_q, hi0_d;
  logic [3:0]  retry_q, retry_d;
  logic        error_q, error_d;
`else
  localparam state_t      FIRST_REQ = REQ_LO;
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    result_d = result_q;
`ifdef COUNTER_SAMPLER_COHERENT_EN
    hi0_d    = hi0_q;
    retry_d  = retry_q;
    error_d  = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST_REQ;
`ifdef COUNTER_SAMPLER_COHERENT_EN
          error_d = 1'b0;
          retry_d = 4'd0;
`endif
        end
      end
`ifdef COUNTER_SAMPLER_COHERENT_EN
      REQ_HI0: if (!avm_waitrequest) state_d = WT_HI0;
      WT_HI0: begin
        if (avm_readdatavalid) begin
          hi0_d   = avm_readdata;
          state_d = REQ_LO;
        end
      end
`endif
      REQ_LO: if (!avm_waitrequest) state_d = WT_LO;
      WT_LO: begin
        if (avm_readdatavalid) begin
          lo_d    = avm_readdata;
          state_d = REQ_HI1;
        end
      end
      REQ_HI1: if (!avm_waitrequest) state_d = WT_HI1;
      WT_HI1: begin
        if (avm_readdatavalid) begin
`ifdef COUNTER_SAMPLER_COHERENT_EN
          // A changed high word means the low word may have wrapped between reads.
          if (avm_readdata == hi0_q) begin
            result_d = {hi0_q, lo_q};
            state_d  = FIN;
          end else if (retry_q < RETRY_MAX) begin
            hi0_d   = avm_readdata;
            retry_d = retry_q + 4'd1;
            state_d = REQ_LO;
          end else begin
            result_d = {avm_readdata, lo_q};
            error_d  = 1'b1;
            state_d  = FIN;
          end
`else
          result_d = {avm_readdata, lo_q};
          state_d  = FIN;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    read_d = (state_d == REQ_HI0) || (state_d == REQ_LO) || (state_d == REQ_HI1);
    addr_d = addr_q;
    if (state_d == REQ_LO) begin
      addr_d = BASE_ADDR;
    end else if ((state_d == REQ_HI0) || (state_d == REQ_HI1)) begin
      addr_d = HI_ADDR;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      result_q <= '0;
      addr_q   <= BASE_ADDR;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTER_SAMPLER_COHERENT_EN
      hi0_q    <= '0;
      retry_q  <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef COUNTER_SAMPLER_COHERENT_EN
      hi0_q    <= hi0_d;
      retry_q  <= retry_d;
      error_q  <= error_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign avm_address = addr_q;
  assign avm_read    = read_q;
`ifdef COUNTER_SAMPLER_COHERENT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: doc/counter_sampler.md
# counter_sampler

Avalon-MM master that captures a coherent 64-bit snapshot of the memory-mapped cycle-counter slave. The counter slave exposes bits 31..0 at byte offset 0 and bits 63..32 at byte offset 4; this block is the reading end of that interface. On a start pulse it issues the reads, guards against low-word carry into the high word, and presents the 64-bit value plus a one-cycle done strobe to local logic such as a measurement or timestamp unit.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the counter slave.
- MAX_RETRY, 3, maximum re-reads after a high-word mismatch before flagging an error (1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request for a snapshot; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle strobe; result and error are valid in that cycle.
- error  out  1  set with done when retries were exhausted; held until the next accepted start.
- result  out  64  last captured counter value; holds between snapshots.
- avm_address  out  32  byte address, either BASE_ADDR or BASE_ADDR+4.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  Avalon read data.
- avm_waitrequest  in  1  slave stall; the request is held while high.
- avm_readdatavalid  in  1  qualifies avm_readdata; at most one read is outstanding.

## Operation
- FSM states: IDLE, REQ_HI0, WT_HI0, REQ_LO, WT_LO, REQ_HI1, WT_HI1, FIN.
- IDLE + start: clear error, clear retry count, go to REQ_HI0 (REQ_LO when coherent reads are compiled out).
- REQ_x: drive avm_read=1 and the address (HI: BASE_ADDR+4, LO: BASE_ADDR). Move to WT_x in the first cycle with avm_waitrequest=0.
- WT_x: avm_read=0. On avm_readdatavalid, latch readdata into hi0, lo, or hi1 and advance HI0→LO→HI1.
- WT_HI1 complete: if hi1==hi0, capture result={hi0,lo} and go to FIN. If they differ and retry<MAX_RETRY, set hi0←hi1, increment retry, and go to REQ_LO. If they differ and retry==MAX_RETRY, capture result={hi1,lo}, set error=1, and go to FIN.
- FIN: done=1 for one cycle, then return to IDLE. busy=1 in every state except IDLE.
- result is written only on entry to FIN. A failed snapshot still overwrites result.
- Counter words are unsigned. No arithmetic is applied to the captured value.

## Timing
- Reset values: avm_read=0, avm_address=BASE_ADDR, busy=0, done=0, error=0, result=0, FSM=IDLE.
- All outputs are registered. avm_address and avm_read change only on clk edges.
- start is sampled in IDLE. busy rises in the next cycle.
- Minimum latency with no wait states and readdatavalid one cycle after acceptance: start@0, then done@7 (coherent) or done@5 (non-coherent).
- Each wait-state cycle and each readdatavalid delay cycle adds one cycle.
- Each retry adds four cycles (REQ_LO, WT_LO, REQ_HI1, WT_HI1) at the minimum.
- start in the same cycle as done: ignored. A new start is accepted only in IDLE, one cycle after done.
- Reset mid-transaction aborts immediately. A readdatavalid arriving after reset deasserts is ignored in IDLE.
- readdatavalid while not in a WT state is ignored.

## Configuration
- COUNTER_SAMPLER_COHERENT_EN defined: hi-lo-hi sequence with retry, as described above. error is functional.
- COUNTER_SAMPLER_COHERENT_EN not defined: REQ_HI0, WT_HI0, and the retry logic are removed. The sequence is REQ_LO→WT_LO→REQ_HI1→WT_HI1→FIN with result={hi1,lo}. error is tied to 0 and MAX_RETRY is unused.

## Test plan
- Basic snapshot: slave model has counter=64'h0000_0001_0000_1234 (frozen), no wait states, start → reads at +4, 0, +4, then done@7 with result=64'h0000_0001_0000_1234 and error=0.
- Carry straddle: high word reads 5 then 6, low word returns 32'h0000_0003 → one retry (LO, HI re-read returning 6), result=64'h0000_0006_0000_0003, error=0.
- Retry exhaustion: MAX_RETRY=2, high word increments on every read → exactly 2 retries, done with error=1 and result={last hi, last lo}; the next start clears error.
- Waitrequest and latency: waitrequest held 3 cycles on each request and readdatavalid delayed 2 cycles → avm_read and avm_address stable while stalled, done@7+3·3+3·1, result correct.
- Reset mid-read: assert reset_n=0 during WT_LO → all outputs at reset values immediately. A late readdatavalid causes no state change; a subsequent start completes normally.
- Start while busy and start on done: extra start pulses produce no additional done strobes; only one done per accepted start.
